// File: rtl/sram_like_slave.sv
// Single-outstanding SRAM-like slave: address handshake, then a fixed-latency
// data_ok pulse. Reads return the full word; writes use byte-lane enables.
module sram_like_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        stall,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_cnt;
    logic                    r_wr;
    logic [3:0]              r_be;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_hs;
    logic                    w_done;
    logic [3:0]              w_be;
    logic                    w_unused_addr;

    // Address bits above the word index alias onto the same memory.
    assign w_unused_addr = ^addr[31:ADDR_WIDTH+2];

    always_comb begin
        w_be = 4'b1111;
        case (size)
            2'd0:    w_be = 4'b0001 << addr[1:0];
            2'd1:    w_be = addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // rst gate keeps addr_ok low while reset holds the FSM in IDLE.
    assign addr_ok = req & ~stall & (r_state == S_IDLE) & ~rst;
    assign w_hs    = addr_ok;
    assign w_done  = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign data_ok = w_done;
    assign rdata   = (w_done && !r_wr) ? r_mem[r_idx] : 32'h0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs)   w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_be    <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_wr    <= wr;
                r_be    <= w_be;
                r_idx   <= addr[ADDR_WIDTH+1:2];
                r_wdata <= wdata;
                r_cnt   <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Memory is deliberately left out of reset; an aborted write never reaches w_done.
    always_ff @(posedge clk) begin
        if (w_done && r_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave: a LATENCY=3 instance for the main
// sequences and a LATENCY=1 instance for back-to-back handshakes.
module tb_sram_like_slave;

    localparam int L0 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, wr = 1'b0, stall = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata;
    logic        addr_ok, data_ok;

    logic        req1 = 1'b0, wr1 = 1'b0, stall1 = 1'b0;
    logic [1:0]  size1 = 2'd0;
    logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
    logic [31:0] rdata1;
    logic        addr_ok1, data_ok1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_like_slave #(.ADDR_WIDTH(10), .LATENCY(L0)) u_dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .stall(stall), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
    );

    sram_like_slave #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1), .addr(addr1),
        .wdata(wdata1), .stall(stall1), .rdata(rdata1), .addr_ok(addr_ok1), .data_ok(data_ok1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the LATENCY=3 instance; nstall cycles of stall
    // precede the handshake and the inputs are scrambled while it is outstanding.
    task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp,
                       input int nstall, input string tag);
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d; stall = (nstall > 0);
        for (int i = 0; i < nstall; i++) begin
            #1;
            chk({tag, "/stall_aok"}, addr_ok, 0);
            tick();
        end
        stall = 1'b0;
        #1;
        chk({tag, "/aok"}, addr_ok, 1);
        tick();
        for (int c = 1; c <= L0; c++) begin
            req = 1'b1; wr = ~w; size = 2'($urandom); addr = $urandom;
            wdata = $urandom; stall = 1'($urandom_range(0, 1));
            #1;
            chk({tag, "/wait_aok"}, addr_ok, 0);
            chk({tag, "/dok"}, data_ok, (c == L0) ? 1 : 0);
            chk({tag, "/rdata"}, rdata, (c == L0) ? exp : 32'h0);
            if (c < L0) tick();
        end
        req = 1'b0; stall = 1'b0;
        tick();
        chk({tag, "/dok_after"}, data_ok, 0);
    endtask

    initial begin
        // reset state, with a request already pending
        req = 1'b1; wr = 1'b0; addr = 32'h10;
        tick(); tick();
        chk("rst/aok", addr_ok, 0);
        chk("rst/dok", data_ok, 0);
        chk("rst/rdata", rdata, 32'h0);
        req = 1'b0;
        rst = 1'b0;

        // word write/read, handshake on the first edge after reset
        txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, "wr10");
        txn(1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, "rd10");

        // byte lanes: foreign lanes of wdata carry junk that must not land
        txn(1'b1, 2'd2, 32'h20, 32'h00000000, 32'h0, 0, "wr20");
        txn(1'b1, 2'd0, 32'h22, 32'h11AA2233, 32'h0, 0, "byte22");
        txn(1'b1, 2'd1, 32'h21, 32'h99881234, 32'h0, 0, "half21");
        txn(1'b0, 2'd2, 32'h20, 32'h0, 32'h00AA1234, 0, "rd20");
        txn(1'b1, 2'd1, 32'h23, 32'h5678ABCD, 32'h0, 0, "half23");
        txn(1'b0, 2'd0, 32'h21, 32'h0, 32'h56781234, 0, "rd20b");

        // size 3 behaves as word, addr[1:0] ignored
        txn(1'b1, 2'd3, 32'h33, 32'h01020304, 32'h0, 0, "sz3");
        txn(1'b0, 2'd2, 32'h30, 32'h0, 32'h01020304, 0, "rd30");

        // stall holds off the handshake for five cycles
        txn(1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 5, "stall");

        // reset one cycle after a write handshake aborts the write
        txn(1'b1, 2'd2, 32'h40, 32'h11111111, 32'h0, 0, "pre40");
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h40; wdata = 32'h55555555;
        #1;
        chk("abort/aok", addr_ok, 1);
        tick();
        req = 1'b0; rst = 1'b1;
        #1;
        chk("abort/dok0", data_ok, 0);
        chk("abort/aok0", addr_ok, 0);
        tick();
        chk("abort/dok1", data_ok, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort/dok_post", data_ok, 0);
            tick();
        end
        txn(1'b0, 2'd2, 32'h40, 32'h0, 32'h11111111, 0, "rd40");

        // aliasing above the 10-bit word index
        txn(1'b1, 2'd2, 32'h00001004, 32'hCAFEF00D, 32'h0, 0, "wr1004");
        txn(1'b0, 2'd2, 32'h00000004, 32'h0, 32'hCAFEF00D, 0, "rd0004");

        // LATENCY=1, req held high: handshake every other cycle
        req1 = 1'b1; wr1 = 1'b1; size1 = 2'd2; addr1 = 32'h8; wdata1 = 32'h12345678;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("b2b/aok", addr_ok1, (k % 2 == 0) ? 1 : 0);
            chk("b2b/dok", data_ok1, (k % 2 == 1) ? 1 : 0);
            chk("b2b/rdata", rdata1, 32'h0);
            tick();
        end
        wr1 = 1'b0;
        #1;
        chk("b2b/rd_aok", addr_ok1, 1);
        tick();
        chk("b2b/rd_dok", data_ok1, 1);
        chk("b2b/rd_aok0", addr_ok1, 0);
        chk("b2b/rd_data", rdata1, 32'h12345678);
        req1 = 1'b0;
        tick();
        chk("b2b/idle_dok", data_ok1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
